// File: rtl/pgm_video_pkg.sv
// Shared types and constants for the PGM text layer renderer.
package pgm_video_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEnt0,
        StEnt1,
        StAttr,
        StGfx,
        StWr
    } txt_state_t;

    localparam int unsigned TXT_MAP_W = 64;
    localparam int unsigned TXT_MAP_H = 32;
    localparam int unsigned TXT_SLOTS = 57;

    localparam int unsigned ATTR_PAL_LSB = 1;
    localparam int unsigned ATTR_PAL_MSB = 5;
    localparam int unsigned ATTR_FLIP_X  = 6;
    localparam int unsigned ATTR_FLIP_Y  = 7;

    // Word address of one map entry: base | {row, col, word}.
    function automatic logic [12:0] map_addr(input logic [12:0] base, input logic [4:0] row,
                                             input logic [5:0] col, input logic w);
        return base | {1'b0, row, col, w};
    endfunction

endpackage

// File: rtl/pgm_line_buffer.sv
// Double-buffered 512x9 scanline store; bank_sel names the displayed bank, writes go to the other.
module pgm_line_buffer (
    input  logic       fixed_20m_clk,
    input  logic       reset_n,
    input  logic       bank_sel,
    input  logic       wr_en,
    input  logic [8:0] wr_addr,
    input  logic [8:0] wr_data,
    input  logic       rd_en,
    input  logic       rd_zero,
    input  logic [8:0] rd_addr,
    output logic [8:0] rd_data
);

    logic [8:0] mem [2][512];

    always_ff @(posedge fixed_20m_clk) begin
        if (wr_en) begin
            mem[~bank_sel][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[bank_sel][rd_addr];
        end
    end

endmodule

// File: rtl/pgm_txt_layer.sv
// PGM text layer: fetches one line of 8x8 4bpp tiles ahead of display into a line buffer.
module pgm_txt_layer
    import pgm_video_pkg::*;
#(
    parameter logic [12:0] TXT_BASE = 13'h1000,
    parameter int unsigned ACTIVE_W = 448
) (
    input  logic        fixed_20m_clk,
    input  logic        reset_n,
    input  logic        hblank,
    input  logic [8:0]  vcount,
    input  logic [8:0]  hcount,
    input  logic        ce_pix,
    input  logic [8:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    output logic [12:0] renderer_vram_addr,
    input  logic [15:0] renderer_vram_dout,
    output logic        gfx_req,
    output logic [18:0] gfx_addr,
    input  logic        gfx_ack,
    input  logic [31:0] gfx_data,
    output logic [8:0]  txt_pix,
    output logic        txt_opaque,
    output logic        overrun
);

    localparam logic signed [10:0] ACTIVE_W_S = 11'(ACTIVE_W);
    localparam logic [5:0]         LAST_SLOT  = 6'(TXT_SLOTS - 1);

    txt_state_t  state_q;
    logic        hblank_q;
    logic        buf_sel_q;
    logic        overrun_q;
    logic [7:0]  y_q;
    logic [8:0]  sx_q;
    logic [5:0]  slot_q;
    logic [2:0]  n_q;
    logic [15:0] tile_q;
    logic [4:0]  pal_q;
    logic        flip_x_q;
    logic [31:0] gfx_data_q;
    logic [12:0] vram_addr_q;
    logic        gfx_req_q;
    logic [18:0] gfx_addr_q;

    logic              swap;
    logic [7:0]        y_now;
    logic [5:0]        col_next;
    logic signed [10:0] wr_x;
    logic [2:0]        pen_idx;
    logic [3:0]        pen;
    logic              wr_en;
    logic              rd_zero;

    assign swap     = hblank & ~hblank_q;
    assign y_now    = 8'(vcount + {1'b0, scroll_y});
    assign col_next = sx_q[8:3] + slot_q + 6'd1;

    // Pixel x may go negative for the leftmost slot when fine-scrolled.
    assign wr_x    = $signed({2'b00, slot_q, n_q}) - $signed({8'b0, sx_q[2:0]});
    assign pen_idx = flip_x_q ? ~n_q : n_q;
    assign pen     = gfx_data_q[{pen_idx, 2'b00} +: 4];
    assign wr_en   = (state_q == StWr) && !swap && !wr_x[10] && (wr_x < ACTIVE_W_S);
    assign rd_zero = ({1'b0, hcount} >= 10'(ACTIVE_W));

    always_ff @(posedge fixed_20m_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hblank_q    <= 1'b0;
            buf_sel_q   <= 1'b0;
            overrun_q   <= 1'b0;
            y_q         <= '0;
            sx_q        <= '0;
            slot_q      <= '0;
            n_q         <= '0;
            tile_q      <= '0;
            pal_q       <= '0;
            flip_x_q    <= 1'b0;
            gfx_data_q  <= '0;
            vram_addr_q <= '0;
            gfx_req_q   <= 1'b0;
            gfx_addr_q  <= '0;
        end else begin
            hblank_q <= hblank;
            if (swap) begin
                // A swap always wins, including over a same-cycle gfx_ack.
                buf_sel_q   <= ~buf_sel_q;
                if (state_q != StIdle) begin
                    overrun_q <= 1'b1;
                end
                state_q     <= StEnt0;
                slot_q      <= '0;
                n_q         <= '0;
                y_q         <= y_now;
                sx_q        <= scroll_x;
                gfx_req_q   <= 1'b0;
                vram_addr_q <= map_addr(TXT_BASE, y_now[7:3], scroll_x[8:3], 1'b0);
            end else begin
                case (state_q)
                    StIdle: ;
                    StEnt0: begin
                        vram_addr_q <= vram_addr_q | 13'd1;
                        state_q     <= StEnt1;
                    end
                    StEnt1: begin
                        tile_q  <= renderer_vram_dout;
                        state_q <= StAttr;
                    end
                    StAttr: begin
                        pal_q      <= renderer_vram_dout[ATTR_PAL_MSB:ATTR_PAL_LSB];
                        flip_x_q   <= renderer_vram_dout[ATTR_FLIP_X];
                        gfx_addr_q <= {tile_q, renderer_vram_dout[ATTR_FLIP_Y] ? ~y_q[2:0]
                                                                                : y_q[2:0]};
                        gfx_req_q  <= 1'b1;
                        state_q    <= StGfx;
                    end
                    StGfx: begin
                        if (gfx_ack) begin
                            gfx_data_q <= gfx_data;
                            gfx_req_q  <= 1'b0;
                            n_q        <= '0;
                            state_q    <= StWr;
                        end
                    end
                    StWr: begin
                        n_q <= n_q + 3'd1;
                        if (n_q == 3'd7) begin
                            if (slot_q == LAST_SLOT) begin
                                state_q <= StIdle;
                            end else begin
                                slot_q      <= slot_q + 6'd1;
                                vram_addr_q <= map_addr(TXT_BASE, y_q[7:3], col_next, 1'b0);
                                state_q     <= StEnt0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    pgm_line_buffer u_line_buffer (
        .fixed_20m_clk (fixed_20m_clk),
        .reset_n       (reset_n),
        .bank_sel      (buf_sel_q),
        .wr_en         (wr_en),
        .wr_addr       (wr_x[8:0]),
        .wr_data       ({pal_q, pen}),
        .rd_en         (ce_pix),
        .rd_zero       (rd_zero),
        .rd_addr       (hcount),
        .rd_data       (txt_pix)
    );

    assign txt_opaque         = |txt_pix[3:0];
    assign renderer_vram_addr = vram_addr_q;
    assign gfx_req            = gfx_req_q;
    assign gfx_addr           = gfx_addr_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_pgm_txt_layer.sv
// Directed self-checking bench for pgm_txt_layer with small VRAM and graphics ROM responders.
module tb_pgm_txt_layer;

    localparam int GFX_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hblank = 1'b0;
    logic [8:0]  vcount = '0;
    logic [8:0]  hcount = '0;
    logic        ce_pix = 1'b0;
    logic [8:0]  scroll_x = '0;
    logic [7:0]  scroll_y = '0;
    logic [12:0] renderer_vram_addr;
    logic [15:0] renderer_vram_dout = '0;
    logic        gfx_req;
    logic [18:0] gfx_addr;
    logic        gfx_ack = 1'b0;
    logic [31:0] gfx_data = '0;
    logic [8:0]  txt_pix;
    logic        txt_opaque;
    logic        overrun;

    logic [15:0] tile_val = 16'h0012;
    logic [15:0] attr_val = 16'h000A;
    logic [31:0] rom_word = 32'h7654_3210;
    int          stall_limit = 1000000000;
    int          acks = 0;
    int          lat_cnt = 0;
    logic [12:0] prev_addr = '0;
    logic        req_prev = 1'b0;
    logic [12:0] addr_log[$];
    logic [18:0] gfx_log[$];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pgm_txt_layer dut (
        .fixed_20m_clk      (clk),
        .reset_n            (reset_n),
        .hblank             (hblank),
        .vcount             (vcount),
        .hcount             (hcount),
        .ce_pix             (ce_pix),
        .scroll_x           (scroll_x),
        .scroll_y           (scroll_y),
        .renderer_vram_addr (renderer_vram_addr),
        .renderer_vram_dout (renderer_vram_dout),
        .gfx_req            (gfx_req),
        .gfx_addr           (gfx_addr),
        .gfx_ack            (gfx_ack),
        .gfx_data           (gfx_data),
        .txt_pix            (txt_pix),
        .txt_opaque         (txt_opaque),
        .overrun            (overrun)
    );

    // VRAM: every entry holds the same tile/attr pair, data one clock after address.
    always @(posedge clk) begin
        renderer_vram_dout <= renderer_vram_addr[0] ? attr_val : tile_val;
        if (renderer_vram_addr != prev_addr && !renderer_vram_addr[0])
            addr_log.push_back(renderer_vram_addr);
        prev_addr <= renderer_vram_addr;
    end

    // Graphics ROM: ack GFX_LAT+1 cycles after req, stalls once acks reaches stall_limit.
    always @(posedge clk) begin
        gfx_ack <= 1'b0;
        if (gfx_req && !req_prev) gfx_log.push_back(gfx_addr);
        req_prev <= gfx_req;
        if (gfx_req && !gfx_ack && acks < stall_limit) begin
            if (lat_cnt == GFX_LAT) begin
                gfx_ack  <= 1'b1;
                gfx_data <= rom_word;
                lat_cnt  <= 0;
                acks     <= acks + 1;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hblank();
        @(negedge clk) hblank = 1'b1;
        @(negedge clk) hblank = 1'b0;
    endtask

    // Fetch a line, swap it to the front, and let the follow-on fetch finish too.
    task automatic fetch_line(input logic [8:0] vc, input logic [8:0] sx, input logic [7:0] sy);
        vcount   = vc;
        scroll_x = sx;
        scroll_y = sy;
        addr_log.delete();
        gfx_log.delete();
        pulse_hblank();
        wait_cycles(1000);
        pulse_hblank();
        wait_cycles(1000);
    endtask

    task automatic read_pix(input int x, output logic [8:0] p, output logic o);
        @(negedge clk);
        hcount = 9'(x);
        ce_pix = 1'b1;
        @(negedge clk);
        ce_pix = 1'b0;
        p = txt_pix;
        o = txt_opaque;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (txt_pix !== 9'd0) $display("FAIL reset_pix got=%h exp=0", txt_pix); else passed++;
        checks++; if (txt_opaque !== 1'b0) $display("FAIL reset_opaque got=%b exp=0", txt_opaque); else passed++;
        checks++; if (gfx_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", gfx_req); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else passed++;
        checks++; if (renderer_vram_addr !== 13'd0) $display("FAIL reset_vaddr got=%h exp=0", renderer_vram_addr); else passed++;
        checks++; if (gfx_addr !== 19'd0) $display("FAIL reset_gaddr got=%h exp=0", gfx_addr); else passed++;
        @(negedge clk) reset_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_basic();
        logic [8:0] p;
        logic o;
        tile_val = 16'h0012; attr_val = 16'h000A; rom_word = 32'h7654_3210;
        fetch_line(9'd0, 9'd0, 8'd0);
        checks++; if (addr_log.size() < 1 || addr_log[0] !== 13'h1000) $display("FAIL basic_addr0 got=%h exp=1000", addr_log.size() > 0 ? addr_log[0] : 13'h0); else passed++;
        checks++; if (gfx_log.size() < 1 || gfx_log[0] !== 19'h00090) $display("FAIL basic_gaddr got=%h exp=00090", gfx_log.size() > 0 ? gfx_log[0] : 19'h0); else passed++;
        for (int x = 0; x < 8; x++) begin
            read_pix(x, p, o);
            checks++; if (p !== 9'(8'h50 + x)) $display("FAIL basic_pix x=%0d got=%h exp=%h", x, p, 9'(8'h50 + x)); else passed++;
            checks++; if (o !== (x != 0)) $display("FAIL basic_opaque x=%0d got=%b exp=%b", x, o, x != 0); else passed++;
        end
        read_pix(447, p, o);
        checks++; if (p !== 9'h057) $display("FAIL basic_last_pix got=%h exp=057", p); else passed++;
        read_pix(448, p, o);
        checks++; if (p !== 9'h000 || o !== 1'b0) $display("FAIL basic_offscreen got=%h/%b exp=000/0", p, o); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL basic_overrun got=%b exp=0", overrun); else passed++;
    endtask

    task automatic test_flip_x();
        logic [8:0] p;
        logic o;
        attr_val = 16'h004A;
        fetch_line(9'd0, 9'd0, 8'd0);
        for (int x = 0; x < 8; x++) begin
            read_pix(x, p, o);
            checks++; if (p !== 9'(8'h57 - x)) $display("FAIL flipx_pix x=%0d got=%h exp=%h", x, p, 9'(8'h57 - x)); else passed++;
        end
        read_pix(7, p, o);
        checks++; if (o !== 1'b0) $display("FAIL flipx_opaque got=%b exp=0", o); else passed++;
    endtask

    task automatic test_flip_y();
        attr_val = 16'h008A;
        fetch_line(9'd2, 9'd0, 8'd0);
        checks++; if (gfx_log.size() < 1 || gfx_log[0] !== {16'h0012, 3'd5}) $display("FAIL flipy_gaddr got=%h exp=%h", gfx_log.size() > 0 ? gfx_log[0] : 19'h0, {16'h0012, 3'd5}); else passed++;
        attr_val = 16'h000A;
        fetch_line(9'd2, 9'd0, 8'd0);
        checks++; if (gfx_log.size() < 1 || gfx_log[0] !== {16'h0012, 3'd2}) $display("FAIL noflipy_gaddr got=%h exp=%h", gfx_log.size() > 0 ? gfx_log[0] : 19'h0, {16'h0012, 3'd2}); else passed++;
    endtask

    task automatic test_scroll();
        logic [8:0] p;
        logic o;
        attr_val = 16'h000A;
        fetch_line(9'd0, 9'd3, 8'd10);
        checks++; if (addr_log.size() < 1 || addr_log[0] !== 13'h1080) $display("FAIL scroll_addr0 got=%h exp=1080", addr_log.size() > 0 ? addr_log[0] : 13'h0); else passed++;
        checks++; if (gfx_log.size() < 1 || gfx_log[0] !== {16'h0012, 3'd2}) $display("FAIL scroll_finey got=%h exp=%h", gfx_log.size() > 0 ? gfx_log[0] : 19'h0, {16'h0012, 3'd2}); else passed++;
        for (int x = 0; x < 6; x++) begin
            read_pix(x, p, o);
            checks++; if (p !== ((x < 5) ? 9'(8'h53 + x) : 9'h050)) $display("FAIL scroll_pix x=%0d got=%h exp=%h", x, p, (x < 5) ? 9'(8'h53 + x) : 9'h050); else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [8:0] p;
        logic o;
        fetch_line(9'd0, 9'h1F8, 8'd0);
        checks++; if (addr_log.size() < 2 || addr_log[0] !== 13'h107E) $display("FAIL wrap_addr0 got=%h exp=107e", addr_log.size() > 0 ? addr_log[0] : 13'h0); else passed++;
        checks++; if (addr_log.size() < 2 || addr_log[1] !== 13'h1000) $display("FAIL wrap_addr1 got=%h exp=1000", addr_log.size() > 1 ? addr_log[1] : 13'h0); else passed++;
        read_pix(9, p, o);
        checks++; if (p !== 9'h051) $display("FAIL wrap_pix got=%h exp=051", p); else passed++;
    endtask

    task automatic test_overrun();
        vcount = 9'd0; scroll_x = 9'd0; scroll_y = 8'd0;
        stall_limit = acks + 3;
        pulse_hblank();
        wait_cycles(200);
        checks++; if (gfx_req !== 1'b1) $display("FAIL stall_req got=%b exp=1", gfx_req); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL stall_overrun_pre got=%b exp=0", overrun); else passed++;
        addr_log.delete();
        @(negedge clk) hblank = 1'b1;
        @(posedge clk) #1;
        checks++; if (gfx_req !== 1'b0) $display("FAIL abort_req got=%b exp=0", gfx_req); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL abort_overrun got=%b exp=1", overrun); else passed++;
        @(negedge clk) hblank = 1'b0;
        wait_cycles(10);
        checks++; if (addr_log.size() < 1 || addr_log[0] !== 13'h1000) $display("FAIL restart_addr got=%h exp=1000", addr_log.size() > 0 ? addr_log[0] : 13'h0); else passed++;
        stall_limit = 1000000000;
        wait_cycles(1000);
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", overrun); else passed++;
    endtask

    task automatic test_reset_mid_wr();
        logic [8:0] p;
        logic o;
        bit seen;
        int req_cycles;
        vcount = 9'd0; scroll_x = 9'd0; scroll_y = 8'd0;
        pulse_hblank();
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk) #1;
            if (gfx_ack) seen = 1;
        end
        checks++; if (!seen) $display("FAIL midwr_ack_timeout got=0 exp=1"); else passed++;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (gfx_req !== 1'b0 || overrun !== 1'b0) $display("FAIL midwr_reset req/ovr got=%b/%b exp=0/0", gfx_req, overrun); else passed++;
        checks++; if (txt_pix !== 9'd0 || renderer_vram_addr !== 13'd0) $display("FAIL midwr_reset pix/addr got=%h/%h exp=0/0", txt_pix, renderer_vram_addr); else passed++;
        wait_cycles(3);
        @(negedge clk) reset_n = 1'b1;
        req_cycles = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gfx_req) req_cycles++;
        end
        checks++; if (req_cycles != 0) $display("FAIL midwr_idle got=%0d exp=0", req_cycles); else passed++;
        fetch_line(9'd0, 9'd0, 8'd0);
        read_pix(1, p, o);
        checks++; if (p !== 9'h051 || o !== 1'b1) $display("FAIL midwr_refetch got=%h/%b exp=051/1", p, o); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL midwr_overrun got=%b exp=0", overrun); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip_x();
        test_flip_y();
        test_scroll();
        test_wrap();
        test_overrun();
        test_reset_mid_wr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
